end_screen_overlay: RTL and testbench

END_SCREEN_OVERLAY -- requirements
Module: end_screen_overlay

---
 rtl/end_screen_overlay_pkg.sv | 19 +
 rtl/end_screen_overlay_vga_delay.sv | 25 ++
 rtl/end_screen_overlay.sv | 178 +++++++++++++++++
 tb/tb_end_screen_overlay.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/end_screen_overlay_pkg.sv
// Shared game definitions: end-screen FSM states, outcome codes and a small sizing helper.
package end_screen_overlay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int OUT_WIN  = 1;
  localparam int OUT_LOSE = 2;
  localparam int OUT_DRAW = 3;

  // Counter width that stays at least one bit for tiny or zero limits.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/end_screen_overlay_vga_delay.sv
// Fixed-latency register pipeline for a bundle of VGA timing/pixel/mouse signals.
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign data_out = pipe[DEPTH-1];

endmodule

// File: rtl/end_screen_overlay.sv
// End-of-game overlay: shows the outcome image over the VGA stream, holds it for a fixed
// time, then turns a select press into a one-cycle back_to_menu pulse.
module end_screen_overlay
  import end_screen_overlay_pkg::*;
#(
  parameter int          TEXT_X       = 256,
  parameter int          TEXT_Y       = 352,
  parameter int          TEXT_W_LOG2  = 8,
  parameter int          TEXT_H_LOG2  = 6,
  parameter int          N_OUT        = 3,
  parameter int          HOLD_CYCLES  = 325000000,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] KEY_COLOR    = 12'hFFF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [10:0]                         hcount_in,
  input  logic [9:0]                          vcount_in,
  input  logic                                hsync_in,
  input  logic                                vsync_in,
  input  logic                                hblnk_in,
  input  logic                                vblnk_in,
  input  logic [11:0]                         rgb_in,
  input  logic [12*N_OUT-1:0]                 rgb_pixel,
  input  logic [$clog2(N_OUT+1)-1:0]          game_end,
  input  logic                                select,
  input  logic [11:0]                         xpos_m,
  input  logic [11:0]                         ypos_m,
  output logic [10:0]                         hcount_out,
  output logic [9:0]                          vcount_out,
  output logic                                hsync_out,
  output logic                                vsync_out,
  output logic                                hblnk_out,
  output logic                                vblnk_out,
  output logic [11:0]                         rgb_out,
  output logic [11:0]                         xpos_m_out,
  output logic [11:0]                         ypos_m_out,
  output logic                                back_to_menu,
  output logic [TEXT_H_LOG2+TEXT_W_LOG2-1:0]  pixel_addr,
  output state_t                              fsm_state
);

  localparam int GW = $clog2(N_OUT+1);
  localparam int CW = $clog2(HOLD_CYCLES+1);
  localparam int FW = clog2_min1(BLINK_FRAMES);
  localparam int PW = 11 + 10 + 4 + 12 + 12;
  localparam int SW = 11 + 10 + 2 + 12;

  logic [TEXT_W_LOG2-1:0] h_rel;
  logic [TEXT_H_LOG2-1:0] v_rel;

  assign h_rel      = TEXT_W_LOG2'(hcount_in - 11'(TEXT_X));
  assign v_rel      = TEXT_H_LOG2'(vcount_in - 10'(TEXT_Y));
  assign pixel_addr = {v_rel, h_rel};

  // Timing and mouse run straight through; rgb gets its own stage-1 tap for the mux.
  vga_delay #(.WIDTH(PW), .DEPTH(2)) u_pass_delay (
    .clk      (clk),
    .rst      (rst),
    .data_in  ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, xpos_m, ypos_m}),
    .data_out ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                xpos_m_out, ypos_m_out})
  );

  logic [10:0] h1;
  logic [9:0]  v1;
  logic        hblnk1, vblnk1;
  logic [11:0] rgb1;

  vga_delay #(.WIDTH(SW), .DEPTH(1)) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .data_in  ({hcount_in, vcount_in, hblnk_in, vblnk_in, rgb_in}),
    .data_out ({h1, v1, hblnk1, vblnk1, rgb1})
  );

  state_t        state, state_next;
  logic [GW-1:0] out_q, out_next;
  logic [CW-1:0] hold_cnt, cnt_next;
  logic          pulse_next;
  logic          ge_valid;

  assign ge_valid  = (game_end != '0) && (int'(game_end) <= N_OUT);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    out_next   = out_q;
    cnt_next   = hold_cnt;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (ge_valid) begin
          state_next = SHOW;
          out_next   = game_end;
          cnt_next   = '0;
        end
      end
      SHOW: begin
        if (game_end == '0)                          state_next = IDLE;
        else if (hold_cnt == CW'(HOLD_CYCLES - 1))   state_next = ARMED;
        else                                         cnt_next   = hold_cnt + CW'(1);
      end
      ARMED: begin
        if (game_end == '0) begin
          state_next = IDLE;
        end else if (select) begin
          state_next = IDLE;
          pulse_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_q        <= '0;
      hold_cnt     <= '0;
      back_to_menu <= 1'b0;
    end else begin
      state        <= state_next;
      out_q        <= out_next;
      hold_cnt     <= cnt_next;
      back_to_menu <= pulse_next;
    end
  end

  // Blink phase counts vsync rising edges only while the box is up; IDLE rearms it visible.
  logic          vsync_prev;
  logic          blink_hidden;
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev   <= 1'b0;
      blink_hidden <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (state == IDLE) begin
        blink_hidden <= 1'b0;
        frame_cnt    <= '0;
      end else if (BLINK_FRAMES != 0 && vsync_in && !vsync_prev) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt    <= '0;
          blink_hidden <= ~blink_hidden;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  logic [11:0] rom_sel;
  logic        in_box;
  logic        show_px;

  always_comb begin
    rom_sel = '0;
    for (int k = 1; k <= N_OUT; k++) begin
      if (int'(out_q) == k) rom_sel = rgb_pixel[12*(k-1) +: 12];
    end
  end

  assign in_box = (int'(h1) >= TEXT_X) && (int'(h1) < TEXT_X + (1 << TEXT_W_LOG2)) &&
                  (int'(v1) >= TEXT_Y) && (int'(v1) < TEXT_Y + (1 << TEXT_H_LOG2));

  assign show_px = (state != IDLE) && select && !blink_hidden && in_box &&
                   !hblnk1 && !vblnk1 && (rom_sel != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (rst) rgb_out <= '0;
    else     rgb_out <= show_px ? rom_sel : rgb1;
  end

endmodule

// File: tb/tb_end_screen_overlay.sv
// Bench for end_screen_overlay: two instances (3 outcomes steady, 2 outcomes blinking)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_end_screen_overlay;
  import end_screen_overlay_pkg::*;

  localparam int HOLD = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos_m, ypos_m;
  logic [35:0] rgb_pixel;
  logic [1:0]  game_end;
  logic        select;

  logic [10:0] hcount_out_a, hcount_out_b;
  logic [9:0]  vcount_out_a, vcount_out_b;
  logic        hsync_out_a, vsync_out_a, hblnk_out_a, vblnk_out_a;
  logic        hsync_out_b, vsync_out_b, hblnk_out_b, vblnk_out_b;
  logic [11:0] rgb_out_a, rgb_out_b, xpos_m_out_a, xpos_m_out_b, ypos_m_out_a, ypos_m_out_b;
  logic        back_to_menu_a, back_to_menu_b;
  logic [13:0] pixel_addr_a, pixel_addr_b;
  state_t      fsm_state_a, fsm_state_b;

  end_screen_overlay #(.N_OUT(3), .HOLD_CYCLES(HOLD), .BLINK_FRAMES(0)) dut_a (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(rgb_pixel), .game_end(game_end), .select(select),
    .xpos_m(xpos_m), .ypos_m(ypos_m),
    .hcount_out(hcount_out_a), .vcount_out(vcount_out_a), .hsync_out(hsync_out_a),
    .vsync_out(vsync_out_a), .hblnk_out(hblnk_out_a), .vblnk_out(vblnk_out_a),
    .rgb_out(rgb_out_a), .xpos_m_out(xpos_m_out_a), .ypos_m_out(ypos_m_out_a),
    .back_to_menu(back_to_menu_a), .pixel_addr(pixel_addr_a), .fsm_state(fsm_state_a)
  );

  end_screen_overlay #(.N_OUT(2), .HOLD_CYCLES(HOLD), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(rgb_pixel[23:0]), .game_end(game_end), .select(select),
    .xpos_m(xpos_m), .ypos_m(ypos_m),
    .hcount_out(hcount_out_b), .vcount_out(vcount_out_b), .hsync_out(hsync_out_b),
    .vsync_out(vsync_out_b), .hblnk_out(hblnk_out_b), .vblnk_out(vblnk_out_b),
    .rgb_out(rgb_out_b), .xpos_m_out(xpos_m_out_b), .ypos_m_out(ypos_m_out_b),
    .back_to_menu(back_to_menu_b), .pixel_addr(pixel_addr_b), .fsm_state(fsm_state_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb, xm, ym;
  } strm_t;

  typedef struct {
    bit          active;
    int          outc;
    int          n;       // edges spent showing since entry, saturating at HOLD
    int          frames;  // vsync rises seen while showing
    bit          vs_prev;
    strm_t       s1, s2;
    logic [11:0] rgb;
    bit          pulse;
  } model_t;

  model_t m [2];
  int n_out_of [2] = '{3, 2};
  int blink_of [2] = '{0, 2};

  function automatic logic [13:0] addr_of(input logic [10:0] h, input logic [9:0] v);
    logic [10:0] dh;
    logic [9:0]  dv;
    dh = h - 11'd256;
    dv = v - 10'd352;
    return {dv[5:0], dh[7:0]};
  endfunction

  function automatic logic [11:0] rom_word(input int k, input logic [13:0] a);
    if (a[2:0] == 3'd5) return 12'hFFF;
    case (k)
      1:       return 12'h0F0;
      2:       return {4'hF, a[7:0]};
      default: return {a[13:6], 4'h1};
    endcase
  endfunction

  function automatic bit in_box(input strm_t s);
    return (s.h >= 256) && (s.h < 512) && (s.v >= 352) && (s.v < 416);
  endfunction

  function automatic model_t step(input model_t mi, input int d, input strm_t cur,
                                  input logic [1:0] ge, input bit sel, input bit r);
    model_t      mo;
    logic [11:0] px;
    bit          hidden;
    bit          rise;
    mo = mi;
    if (r) begin
      mo.active = 0; mo.outc = 0; mo.n = 0; mo.frames = 0; mo.vs_prev = 0;
      mo.s1 = '0; mo.s2 = '0; mo.rgb = '0; mo.pulse = 0;
      return mo;
    end
    px     = rom_word(mi.outc, addr_of(mi.s1.h, mi.s1.v));
    hidden = (blink_of[d] != 0) && (((mi.frames / blink_of[d]) % 2) == 1);
    mo.rgb = (mi.active && sel && !hidden && in_box(mi.s1) && !mi.s1.hb && !mi.s1.vb &&
              px != 12'hFFF) ? px : mi.s1.rgb;
    mo.s2  = mi.s1;
    mo.s1  = cur;
    rise       = cur.vs && !mi.vs_prev;
    mo.vs_prev = cur.vs;
    mo.pulse   = mi.active && (mi.n >= HOLD) && (ge != 0) && sel;
    if (!mi.active)  mo.frames = 0;
    else if (rise)   mo.frames = mi.frames + 1;
    if (!mi.active) begin
      if (ge != 0 && int'(ge) <= n_out_of[d]) begin
        mo.active = 1; mo.outc = int'(ge); mo.n = 0;
      end
    end else if (ge == 0 || mo.pulse) begin
      mo.active = 0;
    end else if (mi.n < HOLD) begin
      mo.n = mi.n + 1;
    end
    return mo;
  endfunction

  function automatic state_t exp_state(input model_t mm);
    if (!mm.active)     return IDLE;
    if (mm.n >= HOLD)   return ARMED;
    return SHOW;
  endfunction

  task automatic check_dut(input int d, input strm_t act, input logic bm,
                           input logic [13:0] pa, input state_t st);
    string pfx;
    strm_t exp_s;
    strm_t act_s;
    pfx = (d == 0) ? "a." : "b.";
    exp_s = m[d].s2; exp_s.rgb = '0;
    act_s = act;     act_s.rgb = '0;
    chk({pfx, "stream_out"}, act_s, exp_s);
    chk({pfx, "rgb_out"}, act.rgb, m[d].rgb);
    chk({pfx, "back_to_menu"}, bm, m[d].pulse);
    chk({pfx, "pixel_addr"}, pa, addr_of(hcount_in, vcount_in));
    chk({pfx, "fsm_state"}, st, exp_state(m[d]));
  endtask

  strm_t cur;
  always @(posedge clk) begin
    cur  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in, xpos_m, ypos_m};
    m[0] = step(m[0], 0, cur, game_end, select, rst);
    m[1] = step(m[1], 1, cur, game_end, select, rst);
    #1;
    check_dut(0, {hcount_out_a, vcount_out_a, hsync_out_a, vsync_out_a, hblnk_out_a,
                  vblnk_out_a, rgb_out_a, xpos_m_out_a, ypos_m_out_a},
              back_to_menu_a, pixel_addr_a, fsm_state_a);
    check_dut(1, {hcount_out_b, vcount_out_b, hsync_out_b, vsync_out_b, hblnk_out_b,
                  vblnk_out_b, rgb_out_b, xpos_m_out_b, ypos_m_out_b},
              back_to_menu_b, pixel_addr_b, fsm_state_b);
  end

  // ---------------- driver ----------------
  // The ROM answers one clock after the address the stream presented.
  task automatic next_cycle();
    logic [13:0] a;
    @(negedge clk);
    a = addr_of(hcount_in, vcount_in);
    rgb_pixel = {rom_word(3, a), rom_word(2, a), rom_word(1, a)};
  endtask

  task automatic idle_inputs();
    hcount_in = 11'd300; vcount_in = 10'd360;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h123; xpos_m = 12'h111; ypos_m = 12'h222;
  endtask

  int first_pulse, pulses;
  bit exp_vis [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; game_end = 2'd0; select = 1'b0; rgb_pixel = '0;
    idle_inputs();
    rgb_in = 12'hABC;
    next_cycle(); next_cycle();
    chk("reset.rgb_out_a", rgb_out_a, 12'h000);
    chk("reset.hcount_out_a", hcount_out_a, 11'd0);
    chk("reset.xpos_m_out_b", xpos_m_out_b, 12'h000);
    chk("reset.back_to_menu_a", back_to_menu_a, 1'b0);
    rst = 1'b0; rgb_in = 12'h123;

    // Win overlay and exit timing with select held high
    game_end = 2'd1; select = 1'b1;
    first_pulse = -1; pulses = 0;
    for (int k = 0; k <= 110; k++) begin
      next_cycle();
      if (back_to_menu_a) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
      if (k == 10) begin
        chk("win.pixel_300_360_a", rgb_out_a, 12'h0F0);
        chk("win.pixel_300_360_b", rgb_out_b, 12'h0F0);
        hcount_in = 11'd200;
      end
      if (k == 13) begin
        chk("win.pixel_200_360_bg", rgb_out_a, 12'h123);
        hcount_in = 11'd301;
      end
      if (k == 16) begin
        chk("win.key_color_bg", rgb_out_a, 12'h123);
        hcount_in = 11'd300;
      end
      if (k == 99)  chk("exit.show_at_99", fsm_state_a, SHOW);
      if (k == 100) chk("exit.armed_at_100", fsm_state_a, ARMED);
    end
    chk("exit.pulse_cycle", first_pulse, 101);
    chk("exit.pulse_count", pulses, 1);

    // select low: no exit until it rises
    select = 1'b0; pulses = 0;
    for (int k = 111; k <= 260; k++) begin
      next_cycle();
      if (back_to_menu_a) pulses++;
    end
    chk("exit.no_pulse_select_low", pulses, 0);
    select = 1'b1;
    next_cycle();
    chk("exit.pulse_on_select", back_to_menu_a, 1'b1);
    next_cycle();
    chk("exit.pulse_one_cycle", back_to_menu_a, 1'b0);

    // Outcome latch, abort, and out-of-range outcomes
    game_end = 2'd2;
    repeat (5) next_cycle();
    chk("latch.win_kept_a", rgb_out_a, 12'h0F0);
    chk("latch.win_kept_b", rgb_out_b, 12'h0F0);
    game_end = 2'd0; pulses = 0;
    next_cycle(); next_cycle();
    chk("abort.idle_a", fsm_state_a, IDLE);
    for (int k = 0; k < 150; k++) begin
      next_cycle();
      if (back_to_menu_a || back_to_menu_b) pulses++;
    end
    chk("abort.no_pulse", pulses, 0);
    game_end = 2'd3;
    repeat (5) next_cycle();
    chk("range.b_stays_idle", fsm_state_b, IDLE);
    chk("range.b_background", rgb_out_b, 12'h123);
    chk("range.a_draw_pixel", rgb_out_a, 12'h201);
    game_end = 2'd0;
    repeat (3) next_cycle();

    // Blink: two frames visible, two hidden
    game_end = 2'd1; select = 1'b1;
    next_cycle();
    for (int r = 0; r < 6; r++) begin
      vsync_in = 1'b1; next_cycle();
      vsync_in = 1'b0; next_cycle(); next_cycle(); next_cycle();
      chk($sformatf("blink.rise%0d_b", r + 1), rgb_out_b, exp_vis[r] ? 12'h0F0 : 12'h123);
      chk($sformatf("blink.rise%0d_a_steady", r + 1), rgb_out_a, 12'h0F0);
    end
    game_end = 2'd0;
    repeat (3) next_cycle();

    // Reset in the middle of SHOW
    game_end = 2'd1; select = 1'b1;
    for (int k = 0; k < 50; k++) next_cycle();
    rst = 1'b1; game_end = 2'd0;
    next_cycle();
    chk("rst_mid.rgb_out_a", rgb_out_a, 12'h000);
    chk("rst_mid.hcount_out_b", hcount_out_b, 11'd0);
    chk("rst_mid.ypos_m_out_a", ypos_m_out_a, 12'h000);
    chk("rst_mid.state_a", fsm_state_a, IDLE);
    rst = 1'b0; pulses = 0;
    for (int k = 51; k <= 110; k++) begin
      next_cycle();
      if (back_to_menu_a || back_to_menu_b) pulses++;
    end
    chk("rst_mid.no_pulse", pulses, 0);

    // Randomised stretch against the model
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 199) == 0) game_end = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)  select = ~select;
      if ($urandom_range(0, 5) == 0)   vsync_in = ~vsync_in;
      hsync_in  = 1'($urandom_range(0, 1));
      hblnk_in  = ($urandom_range(0, 7) == 0);
      vblnk_in  = ($urandom_range(0, 7) == 0);
      hcount_in = 11'($urandom_range(200, 560));
      vcount_in = 10'($urandom_range(330, 430));
      rgb_in    = 12'($urandom_range(0, 4095));
      xpos_m    = 12'($urandom_range(0, 4095));
      ypos_m    = 12'($urandom_range(0, 4095));
    end
    rst = 1'b0;
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
